// File: rtl/bcd_entry_if.sv
// Key inputs and digit/value outputs of the BCD number-entry block.
// master drives the keys, slave is the entry block itself.
interface bcd_entry_if;
  logic       btn_inc;
  logic       btn_sel;
  logic       btn_enter;
  logic [3:0] d_un;
  logic [3:0] d_de;
  logic [6:0] value;
  logic       load;
  logic       editing;
  logic [1:0] digit_sel;

  modport master (
    output btn_inc, btn_sel, btn_enter,
    input  d_un, d_de, value, load,
    input  editing, digit_sel
  );

  modport slave (
    input  btn_inc, btn_sel, btn_enter,
    output d_un, d_de, value, load,
    output editing, digit_sel
  );
endinterface

// File: rtl/bcd_entry.sv
// Two-digit BCD entry from debounced keys; commits the
// value as 7-bit binary with a single-cycle load pulse.
module bcd_entry #(
  parameter int DB_CYCLES = 1_000_000
) (
  input logic        clk,
  input logic        rst,
  bcd_entry_if.slave bus
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    EDIT_UN,
    EDIT_DE,
    COMMIT
  } state_t;

  logic [2:0]    raw;
  logic [2:0]    s1;
  logic [2:0]    s2;
  logic [2:0]    db;
  logic [2:0]    db_q;
  logic [CW-1:0] cnt [3];
  logic [2:0]    ev;
  logic          inc_ev;
  logic          sel_ev;
  logic          ent_ev;

  state_t     state;
  logic [3:0] d_un;
  logic [3:0] d_de;
  logic [6:0] value;
  logic       load;
  logic       editing;
  logic [1:0] digit_sel;
  logic [6:0] bin;

  assign raw = {bus.btn_enter, bus.btn_sel, bus.btn_inc};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1   <= '0;
      s2   <= '0;
      db   <= '0;
      db_q <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      db_q <= db;
      for (int i = 0; i < 3; i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          db[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign ev     = db & ~db_q;
  assign inc_ev = ev[0];
  assign sel_ev = ev[1];
  assign ent_ev = ev[2];

  // d_de*10 + d_un without a multiplier
  assign bin = {d_de, 3'b000}
             + {2'b00, d_de, 1'b0}
             + {3'b000, d_un};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      d_un      <= '0;
      d_de      <= '0;
      value     <= '0;
      load      <= 1'b0;
      editing   <= 1'b0;
      digit_sel <= 2'b00;
    end else begin
      load <= 1'b0;
      if (state == COMMIT) begin
        state     <= IDLE;
        editing   <= 1'b0;
        digit_sel <= 2'b00;
      end else begin
        priority case (1'b1)
          ent_ev: begin
            state     <= COMMIT;
            value     <= bin;
            load      <= 1'b1;
            editing   <= 1'b0;
            digit_sel <= 2'b00;
          end
          sel_ev: begin
            editing <= 1'b1;
            if (state == EDIT_UN) begin
              state     <= EDIT_DE;
              digit_sel <= 2'b10;
            end else begin
              state     <= EDIT_UN;
              digit_sel <= 2'b01;
            end
          end
          inc_ev: begin
            if (state == EDIT_UN)
              d_un <= (d_un == 4'd9) ? 4'd0 : d_un + 4'd1;
            else if (state == EDIT_DE)
              d_de <= (d_de == 4'd9) ? 4'd0 : d_de + 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.d_un      = d_un;
  assign bus.d_de      = d_de;
  assign bus.value     = value;
  assign bus.load      = load;
  assign bus.editing   = editing;
  assign bus.digit_sel = digit_sel;

endmodule
